// File: rtl/gp_prefix_resolver_if.sv
`default_nettype none
// ============================================================================
// Module      : gp_prefix_resolver_if
// Description : Operand / result handshake bundle for gp_prefix_resolver.
//               master : operand producer and result consumer
//               slave  : the resolver itself
//               Signals: in_valid/in_ready/a/b/cin  (operand request)
//                        out_valid/out_ready/sum/cout/grp_p (result)
// Revision    : 1.0 - initial release
// ============================================================================
interface gp_prefix_resolver_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             grp_p;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, grp_p
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, grp_p
    );
endinterface
`default_nettype wire

// File: rtl/gp_prefix_resolver.sv
`default_nettype none
// ============================================================================
// Module      : gp_prefix_resolver
// Description : Sequential Kogge-Stone prefix adder. Captures a, b, cin,
//               forms per-bit generate/propagate, then applies one prefix
//               level per clock (spans 1,2,4,...) reusing a single combine
//               row. Returns sum, carry-out and word propagate.
// Ports       : clk       - rising-edge clock
//               rst_n     - asynchronous active-low reset
//               bus       - gp_prefix_resolver_if.slave handshake bundle
// Revision    : 1.0 - initial release
// ============================================================================
module gp_prefix_resolver #(
    parameter int WIDTH = 8
) (
    input  wire                 clk,
    input  wire                 rst_n,
    gp_prefix_resolver_if.slave bus
);
    localparam int LVLS  = $clog2(WIDTH);
    localparam int LVL_W = (LVLS > 1) ? $clog2(LVLS) : 1;
    localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(LVLS - 1);

    // RESOLVE is the single cycle that turns the finished carries into the
    // registered sum/cout/grp_p before the result is presented in DONE.
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SWEEP   = 2'd1;
    localparam logic [1:0] S_RESOLVE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]       state_q,  state_d;
    logic [LVL_W-1:0] lvl_q,    lvl_d;
    logic [WIDTH-1:0] p_q,      p_d;
    logic [WIDTH-1:0] g_q,      g_d;
    logic [WIDTH-1:0] pp_q,     pp_d;
    logic             cin_q,    cin_d;
    logic [WIDTH-1:0] sum_q,    sum_d;
    logic             cout_q,   cout_d;
    logic             grp_p_q,  grp_p_d;

    logic             in_ready;
    logic             out_valid;

    logic [31:0]      span;
    logic [WIDTH-1:0] lo_mask;
    logic [WIDTH-1:0] g_lvl;
    logic [WIDTH-1:0] pp_lvl;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lvl_q   <= '0;
            p_q     <= '0;
            g_q     <= '0;
            pp_q    <= '0;
            cin_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            grp_p_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            p_q     <= p_d;
            g_q     <= g_d;
            pp_q    <= pp_d;
            cin_q   <= cin_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            grp_p_q <= grp_p_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.in_valid)       state_d = S_SWEEP;
            S_SWEEP:   if (lvl_q == LVL_LAST)  state_d = S_RESOLVE;
            S_RESOLVE:                         state_d = S_DONE;
            S_DONE:    if (bus.out_ready)      state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // One prefix level. Shifting the low operand up by the span aligns
    // bit i-s with bit i. Bits below the span see g_lo=0 and pp_lo=1,
    // which makes the combine an identity there.
    // ------------------------------------------------------------------
    always_comb begin
        span    = 32'd1 << lvl_q;
        lo_mask = ~({WIDTH{1'b1}} << span);
        g_lvl   = g_q | (pp_q & (g_q << span));
        pp_lvl  = pp_q & ((pp_q << span) | lo_mask);
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        lvl_d   = lvl_q;
        p_d     = p_q;
        g_d     = g_q;
        pp_d    = pp_q;
        cin_d   = cin_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        grp_p_d = grp_p_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    p_d    = bus.a ^ bus.b;
                    g_d    = bus.a & bus.b;
                    // Carry-in folded into bit 0 so g[i] becomes the carry out of bit i.
                    g_d[0] = g_d[0] | (p_d[0] & bus.cin);
                    pp_d   = p_d;
                    cin_d  = bus.cin;
                    lvl_d  = '0;
                end
            end
            S_SWEEP: begin
                g_d   = g_lvl;
                pp_d  = pp_lvl;
                lvl_d = lvl_q + 1'b1;
            end
            S_RESOLVE: begin
                sum_d   = p_q ^ {g_q[WIDTH-2:0], cin_q};
                cout_d  = g_q[WIDTH-1];
                grp_p_d = &p_q;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.grp_p     = grp_p_q;

endmodule
`default_nettype wire
